// File: rtl/e_unary_pipe.sv
// Two-stage valid/ready pipeline that classifies a vector as unary (2^k-1) or,
// optionally, complement-unary (~(2^k-1)), with saturating accept/reject counters.
module e_unary_pipe #(
    parameter int unsigned W                     = 16,
    parameter bit          P_ADMIT_COMPLIMENT_EN = 1'b0,
    parameter int unsigned P_CNT_W               = 16,
    localparam int unsigned LW                   = $clog2(W)
) (
    input  logic               clk,
    input  logic               arst_n,
    input  logic               i_vld,
    input  logic [W-1:0]       i_x,
    output logic               o_rdy,
    output logic               o_vld,
    input  logic               i_rdy,
    output logic               o_is_unary,
    output logic               o_is_compl,
    output logic [LW-1:0]      o_len,
    input  logic               i_clr,
    output logic [P_CNT_W-1:0] o_acc_cnt,
    output logic [P_CNT_W-1:0] o_rej_cnt
);

    localparam logic [W-1:0] ONE = W'(1);

    // Count of set bits; only meaningful when the vector is a contiguous low run.
    function automatic logic [LW-1:0] ones_cnt(input logic [W-1:0] v);
        logic [LW:0] n;
        n = '0;
        for (int i = 0; i < int'(W); i++) begin
            n = n + {{LW{1'b0}}, v[i]};
        end
        return n[LW-1:0];
    endfunction

    logic [W-1:0]  x_inv;
    logic          std_hit;
    logic          cmp_hit;
    logic [LW-1:0] len_enc;

    logic          s1_vld;
    logic          s1_std;
    logic          s1_cmp;
    logic [LW-1:0] s1_len;

    logic          s2_vld;
    logic          s2_adv;
    logic          out_hs;

    always_comb begin
        x_inv   = ~i_x;
        // x & (x+1) == 0 marks a run of ones anchored at bit 0; all-ones is excluded.
        std_hit = ((i_x & (i_x + ONE)) == '0) && (i_x != '1);
        cmp_hit = P_ADMIT_COMPLIMENT_EN && ((x_inv & (x_inv + ONE)) == '0) && (x_inv != '1);
        len_enc = std_hit ? ones_cnt(i_x) : ones_cnt(x_inv);
    end

    assign out_hs = s2_vld && i_rdy;
    assign s2_adv = !s2_vld || i_rdy;
    assign o_rdy  = !s1_vld || s2_adv;
    assign o_vld  = s2_vld;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            s1_vld <= 1'b0;
            s1_std <= 1'b0;
            s1_cmp <= 1'b0;
            s1_len <= '0;
        end else if (o_rdy) begin
            s1_vld <= i_vld;
            if (i_vld) begin
                s1_std <= std_hit;
                s1_cmp <= cmp_hit;
                s1_len <= len_enc;
            end
        end
    end

    // Result registers only load on advance, so they hold while stalled.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            s2_vld     <= 1'b0;
            o_is_unary <= 1'b0;
            o_is_compl <= 1'b0;
            o_len      <= '0;
        end else if (s2_adv) begin
            s2_vld <= s1_vld;
            if (s1_vld) begin
                o_is_unary <= s1_std || s1_cmp;
                o_is_compl <= s1_cmp && !s1_std;
                o_len      <= (s1_std || s1_cmp) ? s1_len : '0;
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            o_acc_cnt <= '0;
            o_rej_cnt <= '0;
        end else if (i_clr) begin
            o_acc_cnt <= '0;
            o_rej_cnt <= '0;
        end else if (out_hs) begin
            if (o_is_unary) begin
                if (o_acc_cnt != '1) o_acc_cnt <= o_acc_cnt + P_CNT_W'(1);
            end else begin
                if (o_rej_cnt != '1) o_rej_cnt <= o_rej_cnt + P_CNT_W'(1);
            end
        end
    end

endmodule
